// File: rtl/mac16_stim_pkg.sv
// rtl/mac16_stim_pkg.sv - shared state type and stimulus constants for the MAC16 self-checker
package mac16_stim_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [15:0] A_SEED     = 16'd999;
  localparam logic [15:0] B_SEED     = 16'd12345;
  localparam logic [15:0] A_STEP     = 16'd1;
  localparam logic [15:0] B_STEP     = 16'd3;
  localparam logic [7:0]  ERR_SAT    = 8'd255;
  localparam logic [15:0] NO_ERR_IDX = 16'hFFFF;

endpackage

// File: rtl/mac16_exp_delay.sv
// rtl/mac16_exp_delay.sv - expected-product delay line aligned to the MAC16 pipeline depth
module mac16_exp_delay #(
  parameter int DEPTH = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_exp,
  input  logic [15:0] in_idx,
  output logic        out_valid,
  output logic [31:0] out_exp,
  output logic [15:0] out_idx
);

  logic [DEPTH-1:0] vld_q;
  logic [31:0]      exp_q [DEPTH];
  logic [15:0]      idx_q [DEPTH];

  // Valid bits are the only reset state; a cleared valid makes the payload irrelevant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  // Payload shifts every cycle alongside the valid bits, without reset.
  always_ff @(posedge clk) begin
    exp_q[0] <= in_exp;
    idx_q[0] <= in_idx;
    for (int i = 1; i < DEPTH; i++) begin
      exp_q[i] <= exp_q[i-1];
      idx_q[i] <= idx_q[i-1];
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_exp   = exp_q[DEPTH-1];
  assign out_idx   = idx_q[DEPTH-1];

endmodule

// File: rtl/mac16_stimchk.sv
// rtl/mac16_stimchk.sv - drives a deterministic operand sequence into a MAC16 and checks its products
module mac16_stimchk
  import mac16_stim_pkg::*;
#(
  parameter int NUM_VECTORS = 256,
  parameter int LATENCY     = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dsp_o,
  output logic [15:0] a,
  output logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  err_cnt,
  output logic [15:0] first_err_idx
);

  localparam logic [15:0] LAST_VEC   = 16'(NUM_VECTORS - 1);
  localparam logic [15:0] LAST_DRAIN = 16'(LATENCY - 1);

  state_t      state, state_nxt;
  logic [15:0] k;
  logic        accept_start;
  logic [31:0] prod;
  logic        tail_valid;
  logic [31:0] tail_exp;
  logic [15:0] tail_idx;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: start only matters when not busy; k counts vectors in ISSUE and cycles in DRAIN.
  always_comb begin
    state_nxt    = state;
    accept_start = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept_start = 1'b1;
          state_nxt    = ISSUE;
        end
      end
      ISSUE:   if (k == LAST_VEC)   state_nxt = DRAIN;
      DRAIN:   if (k == LAST_DRAIN) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand generator: seeds load on entry to ISSUE, step each issue cycle, zero otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a <= '0;
      b <= '0;
      k <= '0;
    end else begin
      if (state_nxt != state)                  k <= '0;
      else if (state == ISSUE || state == DRAIN) k <= k + 16'd1;

      if (state_nxt == ISSUE && state != ISSUE) begin
        a <= A_SEED;
        b <= B_SEED;
      end else if (state_nxt == ISSUE) begin
        a <= a + A_STEP;
        b <= b + B_STEP;
      end else begin
        a <= '0;
        b <= '0;
      end
    end
  end

  // Full-width product of the operands currently on the MAC16 inputs.
  assign prod = {16'd0, a} * {16'd0, b};

  mac16_exp_delay #(.DEPTH(LATENCY)) u_exp_delay (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (state == ISSUE),
    .in_exp    (prod),
    .in_idx    (k),
    .out_valid (tail_valid),
    .out_exp   (tail_exp),
    .out_idx   (tail_idx)
  );

  // Result accumulation: clear on an accepted start, count mismatches at the delay-line tail.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt       <= '0;
      first_err_idx <= NO_ERR_IDX;
    end else if (accept_start) begin
      err_cnt       <= '0;
      first_err_idx <= NO_ERR_IDX;
    end else if (tail_valid && (dsp_o != tail_exp)) begin
      if (err_cnt != ERR_SAT) err_cnt <= err_cnt + 8'd1;
      if (err_cnt == 8'd0)    first_err_idx <= tail_idx;
    end
  end

  assign busy = (state == ISSUE) || (state == DRAIN);
  assign done = (state == DONE);
  assign pass = done && (err_cnt == 8'd0);

endmodule

// File: tb/tb_mac16_stimchk.sv
// tb/tb_mac16_stimchk.sv - self-checking bench for mac16_stimchk against a behavioural MAC16 model
module tb_mac16_stimchk;

  localparam int N   = 256;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset, start, start2;
  logic [31:0] dsp_o, dsp_o2;
  logic [15:0] a, b, a2, b2;
  logic        busy, done, pass, busy2, done2, pass2;
  logic [7:0]  err_cnt, err_cnt2;
  logic [15:0] first_err_idx, first_err_idx2;

  int checks = 0;
  int errors = 0;

  int          model_lat = 3;
  bit          stuck = 1'b0;
  bit          corrupt [512];
  logic [31:0] p_prod [8];
  int          p_idx [8];
  int          icnt = 0;

  always #5 clk = ~clk;

  mac16_stimchk #(.NUM_VECTORS(N), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .dsp_o(dsp_o),
    .a(a), .b(b), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .first_err_idx(first_err_idx)
  );

  mac16_stimchk #(.NUM_VECTORS(300), .LATENCY(LAT)) dut300 (
    .clk(clk), .reset(reset), .start(start2), .dsp_o(dsp_o2),
    .a(a2), .b(b2), .busy(busy2), .done(done2), .pass(pass2),
    .err_cnt(err_cnt2), .first_err_idx(first_err_idx2)
  );

  assign dsp_o2 = 32'd0;

  // Behavioural MAC16: product of whatever sits on a/b, returned model_lat cycles later.
  always @(posedge clk) begin
    p_prod[0] <= 32'(a) * 32'(b);
    p_idx[0]  <= (a != 16'd0) ? icnt : -1;
    icnt      <= (a != 16'd0) ? icnt + 1 : 0;
    for (int i = 1; i < 8; i++) begin
      p_prod[i] <= p_prod[i-1];
      p_idx[i]  <= p_idx[i-1];
    end
  end

  always @* begin
    int ti;
    ti = p_idx[model_lat-1];
    if (stuck) dsp_o = 32'd0;
    else if (ti >= 0 && ti < 512 && corrupt[ti]) dsp_o = p_prod[model_lat-1] ^ 32'd1;
    else dsp_o = p_prod[model_lat-1];
  end

  task automatic run(input bit chk_ab, input int restart_at, output int cyc);
    logic [15:0] ea, eb;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_entry done=%b busy=%b required done=0 busy=1", done, busy);
    end
    cyc = 0;
    while (busy === 1'b1 && cyc < 5000) begin
      cyc++;
      if (chk_ab) begin
        if (cyc <= N) begin
          ea = 16'(999 + cyc - 1);
          eb = 16'(12345 + 3 * (cyc - 1));
        end else begin
          ea = 16'd0;
          eb = 16'd0;
        end
        checks++;
        if (a !== ea || b !== eb) begin
          errors++;
          $display("FAIL operands cyc=%0d a=%0d b=%0d required a=%0d b=%0d", cyc, a, b, ea, eb);
        end
        if (cyc == 1 + LAT) begin
          checks++;
          if (dsp_o !== 32'd12332655) begin
            errors++;
            $display("FAIL first_product got=%0d required=12332655", dsp_o);
          end
        end
      end
      start = (cyc == restart_at);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; start2 = 1'b0;
    foreach (corrupt[i]) corrupt[i] = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({a, b, busy, done, pass, err_cnt, first_err_idx} !== {16'd0, 16'd0, 3'b000, 8'd0, 16'hFFFF}) begin
      errors++;
      $display("FAIL reset_state a=%0d b=%0d busy=%b done=%b pass=%b err=%0d first=%h required zeros and first=ffff",
               a, b, busy, done, pass, err_cnt, first_err_idx);
    end
    checks++;
    if ({busy2, done2, pass2, err_cnt2, first_err_idx2} !== {3'b000, 8'd0, 16'hFFFF}) begin
      errors++;
      $display("FAIL reset_state300 busy=%b done=%b err=%0d first=%h", busy2, done2, err_cnt2, first_err_idx2);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ideal;
    int cyc;
    run(1'b1, 0, cyc);
    checks++;
    if (cyc !== N + LAT) begin errors++; $display("FAIL ideal_busy_cycles got=%0d required=%0d", cyc, N + LAT); end
    checks++;
    if ({done, pass, err_cnt, first_err_idx} !== {2'b11, 8'd0, 16'hFFFF}) begin
      errors++;
      $display("FAIL ideal_result done=%b pass=%b err=%0d first=%h required 1 1 0 ffff", done, pass, err_cnt, first_err_idx);
    end
  endtask

  task automatic test_no_compare_in_done;
    stuck = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (err_cnt !== 8'd0 || done !== 1'b1 || pass !== 1'b1) begin
      errors++;
      $display("FAIL done_idle_compare err=%0d done=%b pass=%b required 0 1 1", err_cnt, done, pass);
    end
    stuck = 1'b0;
  endtask

  task automatic test_corrupt5;
    int cyc;
    foreach (corrupt[i]) corrupt[i] = 1'b0;
    corrupt[5] = 1'b1;
    run(1'b0, 0, cyc);
    checks++;
    if (err_cnt !== 8'd1 || first_err_idx !== 16'd5 || pass !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL corrupt5 err=%0d first=%0d pass=%b required 1 5 0", err_cnt, first_err_idx, pass);
    end
    corrupt[5] = 1'b0;
  endtask

  task automatic test_random_corrupt;
    int cyc, n, idx, cnt, mn;
    for (int r = 0; r < 4; r++) begin
      foreach (corrupt[i]) corrupt[i] = 1'b0;
      n = $urandom_range(1, 6);
      cnt = 0;
      mn = 1 << 20;
      for (int j = 0; j < n; j++) begin
        idx = $urandom_range(0, N - 1);
        if (!corrupt[idx]) cnt++;
        corrupt[idx] = 1'b1;
        if (idx < mn) mn = idx;
      end
      run(1'b0, 0, cyc);
      checks++;
      if (err_cnt !== 8'(cnt) || first_err_idx !== 16'(mn) || pass !== 1'b0) begin
        errors++;
        $display("FAIL random_corrupt r=%0d err=%0d first=%0d pass=%b required %0d %0d 0",
                 r, err_cnt, first_err_idx, pass, cnt, mn);
      end
    end
    foreach (corrupt[i]) corrupt[i] = 1'b0;
  endtask

  task automatic test_stuck300;
    int cyc;
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    cyc = 0;
    while (busy2 === 1'b1 && cyc < 5000) begin
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (cyc !== 300 + LAT) begin errors++; $display("FAIL stuck300_cycles got=%0d required=%0d", cyc, 300 + LAT); end
    checks++;
    if (err_cnt2 !== 8'd255 || first_err_idx2 !== 16'd0 || pass2 !== 1'b0 || done2 !== 1'b1) begin
      errors++;
      $display("FAIL stuck300 err=%0d first=%0d pass=%b done=%b required 255 0 0 1", err_cnt2, first_err_idx2, pass2, done2);
    end
  endtask

  task automatic test_latency_mismatch;
    int cyc;
    model_lat = 2;
    run(1'b0, 0, cyc);
    checks++;
    if (pass !== 1'b0 || first_err_idx !== 16'd0 || err_cnt !== 8'd255) begin
      errors++;
      $display("FAIL latency_mismatch pass=%b first=%0d err=%0d required 0 0 255", pass, first_err_idx, err_cnt);
    end
    model_lat = 3;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset_midrun;
    int cyc, w;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    w = 0;
    while (a !== 16'(999 + 100) && w < 1000) begin
      w++;
      @(negedge clk);
    end
    checks++;
    if (w >= 1000) begin errors++; $display("FAIL midrun_reach_k100 timeout a=%0d", a); end
    reset = 1'b1;
    #1;
    checks++;
    if (a !== 16'd0 || b !== 16'd0 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrun_async_reset a=%0d b=%0d done=%b busy=%b required 0 0 0 0", a, b, done, busy);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (a !== 16'd0 || b !== 16'd0 || done !== 1'b0 || err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL midrun_held_reset a=%0d b=%0d done=%b err=%0d required 0 0 0 0", a, b, done, err_cnt);
    end
    reset = 1'b0;
    run(1'b1, 0, cyc);
    checks++;
    if (cyc !== N + LAT || pass !== 1'b1 || first_err_idx !== 16'hFFFF) begin
      errors++;
      $display("FAIL midrun_rerun cyc=%0d pass=%b first=%h required %0d 1 ffff", cyc, pass, first_err_idx, N + LAT);
    end
  endtask

  task automatic test_start_ignored;
    int cyc;
    run(1'b1, 11, cyc);
    checks++;
    if (cyc !== N + LAT || pass !== 1'b1 || err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL start_ignored cyc=%0d pass=%b err=%0d required %0d 1 0", cyc, pass, err_cnt, N + LAT);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    corrupt[7] = 1'b1;
    run(1'b0, 0, cyc);
    corrupt[7] = 1'b0;
    run(1'b1, 0, cyc);
    checks++;
    if (cyc !== N + LAT || pass !== 1'b1 || err_cnt !== 8'd0 || first_err_idx !== 16'hFFFF) begin
      errors++;
      $display("FAIL back_to_back cyc=%0d pass=%b err=%0d first=%h required %0d 1 0 ffff",
               cyc, pass, err_cnt, first_err_idx, N + LAT);
    end
  endtask

  initial begin
    test_reset;
    test_ideal;
    test_no_compare_in_done;
    test_corrupt5;
    test_random_corrupt;
    test_stuck300;
    test_latency_mismatch;
    test_reset_midrun;
    test_start_ignored;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
